// File: rtl/pal_sync_decoder.sv
// pal_sync_decoder: recovers raster timing (line length, frame height, counters, lock, mode)
// from an active-low hsync/vsync pair.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clken             pixel-rate enable; all measurement state advances only when high
//   hsync, vsync      active-low sync inputs, synchronous to clk
//   hcnt, vcnt        pixel / line position since the last hsync / vsync falling edge
//   line_len          last measured pixels per line minus 1
//   frame_lines       last measured lines per frame minus 1
//   locked            horizontal and vertical measurements stable
//   mode, mode_valid  decoded timing mode (48K/128K/Pentagon/NTSC) and its qualifier
//   new_frame         one-clk pulse per vsync falling edge
module pal_sync_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       hsync,
    input  logic       vsync,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic [8:0] line_len,
    output logic [8:0] frame_lines,
    output logic       locked,
    output logic [1:0] mode,
    output logic       mode_valid,
    output logic       new_frame
);
    logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [8:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic       h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic       h_ok_q, h_ok_d, v_ok_q, v_ok_d;
    logic       locked_q, locked_d, new_frame_q, new_frame_d;
    logic       hs_fall, vs_fall;
    logic [8:0] meas;
    logic       m48, m128, mpent, mntsc;

    always_comb begin
        hs_fall   = clken & hs_prev_q & ~hsync;
        vs_fall   = clken & vs_prev_q & ~vsync;
        hs_prev_d = clken ? hsync : hs_prev_q;
        vs_prev_d = clken ? vsync : vs_prev_q;
        hcnt_d    = hs_fall ? 9'd0 : (clken && hcnt_q != 9'd511) ? hcnt_q + 9'd1 : hcnt_q;
        vcnt_d    = vs_fall ? 9'd0 : (hs_fall && vcnt_q != 9'd511) ? vcnt_q + 9'd1 : vcnt_q;
        // a vsync edge that coincides with an hsync edge has not yet counted that line
        meas          = hs_fall ? vcnt_q : vcnt_q - 9'd1;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        h_ok_d        = h_ok_q;
        v_ok_d        = v_ok_q;
        if (hs_fall) begin
            // a saturated count means the previous edge is too old to measure from
            if (h_seen_q && hcnt_q != 9'd511) begin
                h_ok_d     = hcnt_q == line_len_q;
                line_len_d = hcnt_q;
            end
            h_seen_d = 1'b1;
        end else if (hcnt_d == 9'd511) begin
            h_seen_d = 1'b0;
            h_ok_d   = 1'b0;
        end
        if (vs_fall) begin
            if (v_seen_q) begin
                v_ok_d        = meas == frame_lines_q;
                frame_lines_d = meas;
            end
            v_seen_d = 1'b1;
        end else if (vcnt_d == 9'd511) begin
            v_seen_d = 1'b0;
            v_ok_d   = 1'b0;
        end
        locked_d    = h_ok_q & v_ok_q;
        new_frame_d = vs_fall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            hcnt_q        <= 9'd0;
            vcnt_q        <= 9'd0;
            line_len_q    <= 9'd0;
            frame_lines_q <= 9'd0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            h_ok_q        <= 1'b0;
            v_ok_q        <= 1'b0;
            locked_q      <= 1'b0;
            new_frame_q   <= 1'b0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            h_ok_q        <= h_ok_d;
            v_ok_q        <= v_ok_d;
            locked_q      <= locked_d;
            new_frame_q   <= new_frame_d;
        end
    end

    always_comb begin
        m48        = line_len_q == 9'd447 && frame_lines_q == 9'd311;
        m128       = line_len_q == 9'd455 && frame_lines_q == 9'd310;
        mpent      = line_len_q == 9'd447 && frame_lines_q == 9'd319;
        mntsc      = line_len_q == 9'd447 && frame_lines_q == 9'd261;
        mode       = mntsc ? 2'b11 : mpent ? 2'b10 : m128 ? 2'b01 : 2'b00;
        mode_valid = locked_q & (m48 | m128 | mpent | mntsc);
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign new_frame   = new_frame_q;
endmodule
